// File: rtl/phase_sync_pkg.sv
// Shared types and helpers for the multi-channel phase synchroniser.
package phase_sync_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_LOCKED = 2'd3
  } state_e;

  // Behaviour once locked: single event or every zero passage
  typedef enum logic {
    MODE_ONESHOT  = 1'b0,
    MODE_PERIODIC = 1'b1
  } mode_e;

  // Zero-point detection method
  typedef enum logic {
    DET_WINDOW = 1'b0,
    DET_WRAP   = 1'b1
  } det_e;

  // Upper bounds for the channel extraction helper; the packed bus is
  // zero-extended to MAX_BUS_W before the shift.
  localparam int unsigned MAX_BUS_W   = 2048;
  localparam int unsigned MAX_PHASE_W = 64;

  // Returns channel k (width w) from the packed accumulator bus, right aligned.
  function automatic logic [MAX_PHASE_W-1:0] get_channel(
    input logic [MAX_BUS_W-1:0] bus,
    input logic [31:0]          k,
    input logic [31:0]          w
  );
    logic [MAX_BUS_W-1:0] shifted;
    shifted = bus >> (k * w);
    return shifted[MAX_PHASE_W-1:0];
  endfunction

endpackage

// File: rtl/phase_zero_detect.sv
// Zero-phase comparators for one accumulator sample, plus the previous-sample
// register used to recognise a true accumulator wrap.
module phase_zero_detect
  import phase_sync_pkg::*;
#(
  parameter int PHASE_W = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  det_e               det_sel_i,
  input  logic [PHASE_W-1:0] thr_i,
  input  logic [PHASE_W-1:0] phase_i,
  output logic               hit_o,
  output logic               prev_valid_o
);

  logic [PHASE_W-1:0] prev_q;
  logic               valid_q;
  logic               win_hit_s;
  logic               wrap_hit_s;

  // Raw compare: window around zero (both sides) or decreasing sample.
  // ~thr equals 2^PHASE_W-1-thr, so thr=0 never hits and thr>=half range
  // always hits without any special casing.
  always_comb begin
    win_hit_s  = (phase_i < thr_i) || (phase_i > ~thr_i);
    wrap_hit_s = (phase_i < prev_q);
    if (det_sel_i == DET_WRAP) begin
      hit_o = wrap_hit_s;
    end else begin
      hit_o = win_hit_s;
    end
  end

  // Track the previous sample while enabled; the valid flag marks that
  // prev_q holds a sample from the current tracking run.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q  <= '0;
      valid_q <= 1'b0;
    end else if (en_i) begin
      prev_q  <= phase_i;
      valid_q <= 1'b1;
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign prev_valid_o = valid_q;

endmodule

// File: rtl/phase_sync_mc.sv
// Multi-channel phase synchroniser: after arming and a programmable delay,
// locks onto the zero-phase point of a selected DDS accumulator and issues
// sync level, strobe and event count to the downstream sequencer.
module phase_sync_mc
  import phase_sync_pkg::*;
#(
  parameter int PHASE_W  = 32,
  parameter int NCH      = 4,
  parameter int DELAY_W  = 16,
  parameter int CNT_W    = 16,
  parameter int TIMEOUT  = 0,
  parameter int AUTO_ARM = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  arm,
  input  logic                                  abort,
  input  logic                                  mode,
  input  logic                                  det_sel,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] ch_sel,
  input  logic [DELAY_W-1:0]                    delay_reg,
  input  logic [PHASE_W-1:0]                    threshold,
  input  logic [NCH*PHASE_W-1:0]                phase_accum,
  output logic                                  sync_pulse,
  output logic                                  sync_strobe,
  output logic [CNT_W-1:0]                      sync_count,
  output logic                                  busy,
  output logic                                  timeout
);

  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  state_e             state_q, state_d;
  logic [DELAY_W-1:0] dcnt_q, dcnt_d;
  logic [TO_W-1:0]    wcnt_q, wcnt_d;
  mode_e              mode_q, mode_d;
  det_e               det_q, det_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [PHASE_W-1:0] thr_q, thr_d;
  logic               pulse_q, pulse_d;
  logic               strobe_q, strobe_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               timeout_q, timeout_d;
  logic               busy_q, busy_d;
  logic               hit_prev_q, hit_prev_d;
  logic               first_q;

  logic               arm_s;
  logic               tracking_s;
  logic [CH_W-1:0]    ch_clamp_s;
  logic [PHASE_W-1:0] sel_phase_s;
  logic               raw_hit_s;
  logic               prev_valid_s;
  logic               hit_s;
  logic               new_event_s;
  logic [CNT_W-1:0]   count_inc_s;

  // The auto-arm event is the first clock after reset release.
  assign arm_s      = arm | first_q;
  assign tracking_s = (state_q == ST_WAIT) || (state_q == ST_LOCKED);

  // Channel select clamp, reference sample mux, hit qualification and
  // saturating count increment.
  always_comb begin
    if (32'(ch_sel) > 32'(NCH - 1)) begin
      ch_clamp_s = CH_W'(NCH - 1);
    end else begin
      ch_clamp_s = ch_sel;
    end
    sel_phase_s = PHASE_W'(get_channel(MAX_BUS_W'(phase_accum), 32'(ch_q), 32'(PHASE_W)));
    // Wrap compare is meaningless until one sample of this run is stored.
    hit_s = raw_hit_s && ((det_q == DET_WINDOW) || prev_valid_s);
    // Window hits last several cycles; only the rising edge counts as an event.
    if (det_q == DET_WRAP) begin
      new_event_s = hit_s;
    end else begin
      new_event_s = hit_s && !hit_prev_q;
    end
    if (count_q == {CNT_W{1'b1}}) begin
      count_inc_s = count_q;
    end else begin
      count_inc_s = count_q + CNT_W'(1);
    end
  end

  phase_zero_detect #(
    .PHASE_W (PHASE_W)
  ) u_detect (
    .clk_i        (clk),
    .rst_ni       (rst),
    .en_i         (tracking_s),
    .det_sel_i    (det_q),
    .thr_i        (thr_q),
    .phase_i      (sel_phase_s),
    .hit_o        (raw_hit_s),
    .prev_valid_o (prev_valid_s)
  );

  // Sequencer next state, latched configuration and output next values.
  always_comb begin
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    wcnt_d    = wcnt_q;
    mode_d    = mode_q;
    det_d     = det_q;
    ch_d      = ch_q;
    thr_d     = thr_q;
    pulse_d   = pulse_q;
    strobe_d  = 1'b0;
    count_d   = count_q;
    timeout_d = timeout_q;
    if (abort) begin
      // Cancel keeps the count and timeout flag for post-mortem reading.
      state_d = ST_IDLE;
      pulse_d = 1'b0;
    end else if (arm_s) begin
      mode_d    = mode_e'(mode);
      det_d     = det_e'(det_sel);
      ch_d      = ch_clamp_s;
      thr_d     = threshold;
      dcnt_d    = delay_reg;
      pulse_d   = 1'b0;
      count_d   = '0;
      timeout_d = 1'b0;
      state_d   = ST_DELAY;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_DELAY: begin
          if (dcnt_q == '0) begin
            wcnt_d  = '0;
            state_d = ST_WAIT;
          end else begin
            dcnt_d = dcnt_q - DELAY_W'(1);
          end
        end
        ST_WAIT: begin
          if (hit_s) begin
            pulse_d  = 1'b1;
            strobe_d = 1'b1;
            count_d  = count_inc_s;
            state_d  = ST_LOCKED;
          end else if ((TIMEOUT > 0) && (wcnt_q == TO_LAST)) begin
            timeout_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            wcnt_d = wcnt_q + TO_W'(1);
          end
        end
        ST_LOCKED: begin
          if ((mode_q == MODE_PERIODIC) && new_event_s) begin
            strobe_d = 1'b1;
            count_d  = count_inc_s;
          end else begin
            pulse_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          pulse_d = 1'b0;
        end
      endcase
    end
    hit_prev_d = tracking_s && hit_s;
    busy_d     = (state_d != ST_IDLE);
  end

  // State, configuration and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      dcnt_q     <= '0;
      wcnt_q     <= '0;
      mode_q     <= MODE_ONESHOT;
      det_q      <= DET_WINDOW;
      ch_q       <= '0;
      thr_q      <= '0;
      pulse_q    <= 1'b0;
      strobe_q   <= 1'b0;
      count_q    <= '0;
      timeout_q  <= 1'b0;
      busy_q     <= 1'b0;
      hit_prev_q <= 1'b0;
      first_q    <= (AUTO_ARM != 0);
    end else begin
      state_q    <= state_d;
      dcnt_q     <= dcnt_d;
      wcnt_q     <= wcnt_d;
      mode_q     <= mode_d;
      det_q      <= det_d;
      ch_q       <= ch_d;
      thr_q      <= thr_d;
      pulse_q    <= pulse_d;
      strobe_q   <= strobe_d;
      count_q    <= count_d;
      timeout_q  <= timeout_d;
      busy_q     <= busy_d;
      hit_prev_q <= hit_prev_d;
      first_q    <= 1'b0;
    end
  end

  assign sync_pulse  = pulse_q;
  assign sync_strobe = strobe_q;
  assign sync_count  = count_q;
  assign busy        = busy_q;
  assign timeout     = timeout_q;

endmodule
